// File: rtl/thumb_fetch_unit.sv
// Thumb instruction fetch stage: owns the fetch PC, issues halfword fetches to a
// 1-cycle synchronous instruction memory and queues returns in order for decode.
module thumb_fetch_unit #(
    parameter int              WORD      = 32,
    parameter logic [WORD-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            take_branch_i,
    input  logic            flush_pipeline_i,
    input  logic [WORD-1:0] branch_target_i,
    input  logic            stall_i,
    output logic            imem_req_o,
    output logic [WORD-1:0] imem_addr_o,
    input  logic [15:0]     imem_data_i,
    output logic [15:0]     instruction_o,
    output logic [WORD-1:0] program_counter_o,
    output logic            is_valid_o
);

    localparam int              PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int              CW        = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0]   LAST_PTR  = PW'(BUF_DEPTH - 1);
    localparam logic [WORD-1:0] HALF_MASK = ~(WORD'(1));

    typedef enum logic {
        ST_RUN,
        ST_REDIRECT
    } state_t;

    state_t          state_q, state_d;
    logic [WORD-1:0] fetch_pc_q;
    logic [WORD-1:0] inflight_addr_q;
    logic [WORD-1:0] redirect_pc;
    logic            inflight_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [15:0]     buf_data_q [BUF_DEPTH];
    logic [WORD-1:0] buf_addr_q [BUF_DEPTH];
    logic            redirect, pop, push;
    logic [CW:0]     occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign redirect   = take_branch_i | flush_pipeline_i;
    assign is_valid_o = (count_q != '0);
    assign pop        = is_valid_o & ~stall_i;
    // A squashing edge discards the return of the in-flight fetch.
    assign push       = inflight_q & ~redirect;
    assign occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    assign imem_addr_o       = fetch_pc_q;
    assign instruction_o     = is_valid_o ? buf_data_q[rd_ptr_q] : '0;
    assign program_counter_o = is_valid_o ? buf_addr_q[rd_ptr_q] + WORD'(4) : '0;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d    = ST_RUN;
        imem_req_o = 1'b0;
        unique case (state_q)
            ST_RUN:      imem_req_o = (occupancy < (CW+1)'(BUF_DEPTH));
            ST_REDIRECT: imem_req_o = 1'b1;
            default:     imem_req_o = 1'b0;
        endcase
        if (redirect) state_d = ST_REDIRECT;
        if (reset_i)  imem_req_o = 1'b0;
    end

    // Replay restarts at the oldest instruction not yet handed to decode.
    always_comb begin
        if (take_branch_i)   redirect_pc = branch_target_i & HALF_MASK;
        else if (is_valid_o) redirect_pc = buf_addr_q[rd_ptr_q];
        else if (inflight_q) redirect_pc = inflight_addr_q;
        else                 redirect_pc = fetch_pc_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset_i) begin
            state_q         <= ST_RUN;
            fetch_pc_q      <= RESET_PC & HALF_MASK;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            count_q         <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                fetch_pc_q <= redirect_pc;
                inflight_q <= 1'b0;
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                inflight_q <= imem_req_o;
                if (imem_req_o) begin
                    inflight_addr_q <= fetch_pc_q;
                    fetch_pc_q      <= fetch_pc_q + WORD'(2);
                end
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) begin
            buf_data_q[wr_ptr_q] <= imem_data_i;
            buf_addr_q[wr_ptr_q] <= inflight_addr_q;
        end
    end

endmodule
